mux_16x1_rr_arbiter: RTL and testbench
======================================

# mux_16x1_rr_arbiter

Round-robin arbiter that shares one `mux_16x1` among 16 requesters. Each requester drives one bit of the mux data input. The arbiter grants one requester at a time and drives the mux select to that requester's index. `data_out` carries the granted requester's bit while a grant is active. Grants are released by a `done` handshake, by request withdrawal, or by a hold-time limit, so no requester can starve the others.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles a single grant may last. Legal range 0..255; 0 means no limit.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `req`  input  16  request vector; `req[i]` is requester i.
- `done`  input  1  the current grantee releases the mux; sampled only while `valid`=1.
- `data_in`  input  16  per-requester data bits; connected to the internal `mux_16x1` `in` port.
- `grant`  output  16  one-hot registered grant; all zero when idle.
- `sel`  output  4  registered mux select; equals the index of the set `grant` bit.
- `valid`  output  1  registered; 1 while a grant is active.
- `data_out`  output  1  combinational: `data_in[sel]` when `valid`=1, else 0.

## Operation
- The clock is `clk`; reset is asynchronous and active-low on `rst_n`.
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the mux.
- Priority pointer `ptr` (4 bit):
  - Search order is `ptr`, `ptr`+1, …, wrapping modulo 16.
  - After each new grant to index w, `ptr` becomes (w+1) mod 16, so the last winner has lowest priority.
- IDLE:
  - If `req`≠0, the winner is chosen by the search order. At the next edge: `grant`=1<<w, `sel`=w, `valid`=1, state goes to GRANT, hold count set to 1.
  - If `req`=0, state stays IDLE. `sel` holds its last value; `grant` and `valid` stay 0.
- GRANT, release condition (any one of the following, evaluated each cycle):
  - `done`=1;
  - `req[sel]`=0;
  - `MAX_HOLD`≠0 and hold count = `MAX_HOLD`.
- GRANT, no release: the grant holds, and the hold count increments, saturating at 255.
- GRANT, release:
  - Re-arbitration uses the current `req` with the updated `ptr`, so the releasing requester is last in order.
  - If a winner exists, the new grant appears at the next edge with no idle gap, and the hold count resets to 1.
  - If no winner exists, state goes to IDLE and `valid`=0 at the next edge.
- The releasing requester may win again immediately only if it is the sole requester.
- `done` is ignored while `valid`=0.
- Bits of `req` that change while another requester holds the grant do not affect that grant.

## Timing
- Reset values: `grant`=16'h0000, `sel`=4'h0, `valid`=0, `ptr`=0, hold count=0, state=IDLE. `data_out`=0 follows combinationally.
- Reset takes effect asynchronously mid-grant. The first arbitration after reset release uses `ptr`=0.
- Request-to-grant latency is 1 cycle.
- Release-to-next-grant latency is 1 cycle (back-to-back).
- Grant duration:
  - With `done` pulsed in grant cycle k, the grant lasts k cycles.
  - With the timeout, the grant lasts exactly `MAX_HOLD` cycles.
- `grant`, `sel` and `valid` change only on `clk` edges or on reset; they are glitch-free.
- `data_out` has combinational latency 0 from `data_in`.
- Invariants:
  - `grant` is one-hot when `valid`=1 and zero otherwise.
  - `sel` always matches `grant`.

## Test plan
- Reset mid-grant: grant index 5 active, assert `rst_n`=0 between edges → `grant`=0, `valid`=0, `sel`=0 immediately, with no clock edge needed.
- Single request: `req`=16'h0020, `data_in`=16'h0020 → next edge `grant`=16'h0020, `sel`=5, `valid`=1, `data_out`=1. Pulse `done` → next edge `valid`=0, `grant`=0, `sel` stays 5.
- Fairness and wrap-around:
  - `req`=16'h8001 held, `done` pulsed every grant → grant indices 0, 15, 0, 15 with no idle cycles.
  - Then set `req`=16'h0003 after winner 15 → indices 0, 1.
- Timeout with `MAX_HOLD`=4: `req`=16'h0088 held, no `done` → index 3 granted for 4 cycles, then index 7 for 4 cycles, then index 3 again.
- Withdrawal and stray done:
  - Grantee 2 drops `req[2]` → release at the next edge.
  - `done`=1 while `valid`=0 → no effect; the next request is granted normally.
- Simultaneous events: `done` of grantee 4 in the same cycle that `req[9]` rises, with `req`=16'h0210 → next edge `grant`=16'h0200, `sel`=9, and requester 4 is re-granted only afterward.

Source files
------------

// File: rtl/mux_16x1_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 mux among 16 requesters.
// A grant ends on done, on request withdrawal, or when it reaches MAX_HOLD cycles.

module mux_16x1 (
    input  logic [15:0] in,
    input  logic [3:0]  sel,
    output logic        out
);
    assign out = in[sel];
endmodule

module mux_16x1_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    input  logic [15:0] data_in,
    output logic [15:0] grant,
    output logic [3:0]  sel,
    output logic        valid,
    output logic        data_out
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t      state, state_d;
    logic [3:0]  ptr, ptr_d;
    logic [7:0]  hold, hold_d;
    logic [15:0] grant_d;
    logic [3:0]  sel_d;
    logic        valid_d;
    logic        found;
    logic [3:0]  win;
    logic        rel;
    logic        mux_out;

    // First requesting index at or after ptr, wrapping modulo 16.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int i = 0; i < 16; i++) begin
            if (!found && req[ptr + 4'(i)]) begin
                found = 1'b1;
                win   = ptr + 4'(i);
            end
        end
    end

    always_comb begin
        rel = (state == GRANT) &&
              (done || !req[sel] || (MAX_HOLD != 0 && hold == HOLD_LIMIT));
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state;
        ptr_d   = ptr;
        hold_d  = hold;
        grant_d = grant;
        sel_d   = sel;
        valid_d = valid;

        if (state == IDLE || rel) begin
            if (found) begin
                state_d = GRANT;
                grant_d = 16'(1) << win;
                sel_d   = win;
                valid_d = 1'b1;
                ptr_d   = win + 4'd1;
                hold_d  = 8'd1;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        end else if (hold != 8'hFF) begin
            hold_d = hold + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            hold  <= '0;
            grant <= '0;
            sel   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            hold  <= hold_d;
            grant <= grant_d;
            sel   <= sel_d;
            valid <= valid_d;
        end
    end

    mux_16x1 u_mux (
        .in  (data_in),
        .sel (sel),
        .out (mux_out)
    );

    assign data_out = valid & mux_out;
endmodule

// File: tb/tb_mux_16x1_rr_arbiter.sv
// Bench for mux_16x1_rr_arbiter: directed scenarios plus random traffic checked
// against a round-robin reference model.

module tb_mux_16x1_rr_arbiter;
    localparam int MH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] data_in;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        valid;
    logic        data_out;

    int total = 0;
    int bad   = 0;

    // Reference model: owner index (-1 when idle), priority pointer, hold count.
    int         m_owner;
    int         m_ptr;
    int         m_hold;
    logic [3:0] m_sel;

    mux_16x1_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .done     (done),
        .data_in  (data_in),
        .grant    (grant),
        .sel      (sel),
        .valid    (valid),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_sel   = 4'd0;
    endtask

    task automatic model_step();
        bit rearb;
        int w;
        if (m_owner >= 0)
            rearb = done || !req[m_owner] || (MH != 0 && m_hold == MH);
        else
            rearb = 1'b1;
        if (rearb) begin
            w = -1;
            for (int k = 0; k < 16; k++)
                if (w < 0 && req[(m_ptr + k) % 16]) w = (m_ptr + k) % 16;
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = (w + 1) % 16;
                m_hold  = 1;
                m_sel   = 4'(w);
            end else begin
                m_owner = -1;
            end
        end else if (m_hold < 255) begin
            m_hold++;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [15:0] eg;
        logic        ed;
        eg = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
        ed = (m_owner >= 0) ? data_in[m_owner] : 1'b0;
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".sel"}, 32'(sel), 32'(m_sel));
        check({tag, ".valid"}, 32'(valid), 32'(m_owner >= 0));
        check({tag, ".data_out"}, 32'(data_out), 32'(ed));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        done    = 1'b0;
        data_in = '0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all("reset");
        rst_n = 1'b1;

        // Single request, then done with request dropped.
        req = 16'h0020; data_in = 16'h0020;
        step("single");
        check("single_grant", 32'(grant), 32'h0020);
        check("single_sel", 32'(sel), 32'd5);
        check("single_dout", 32'(data_out), 32'd1);
        req = '0; done = 1'b1;
        step("single_rel");
        check("single_rel_valid", 32'(valid), 32'd0);
        check("single_rel_sel", 32'(sel), 32'd5);
        done = 1'b0;

        // Asynchronous reset mid-grant.
        req = 16'h0020;
        step("pre_reset");
        check("pre_reset_sel", 32'(sel), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_grant", 32'(grant), 32'h0);
        check("async_rst_valid", 32'(valid), 32'd0);
        check("async_rst_sel", 32'(sel), 32'd0);
        req = '0;
        rst_n = 1'b1;

        // Fairness and wrap-around, done every grant.
        req = 16'h8001; done = 1'b1;
        step("fair0"); check("fair0_sel", 32'(sel), 32'd0);
        step("fair1"); check("fair1_sel", 32'(sel), 32'd15);
        step("fair2"); check("fair2_sel", 32'(sel), 32'd0);
        step("fair3"); check("fair3_sel", 32'(sel), 32'd15);
        req = 16'h0003;
        step("wrap0"); check("wrap0_sel", 32'(sel), 32'd0);
        step("wrap1"); check("wrap1_sel", 32'(sel), 32'd1);
        req = '0;
        step("fair_idle");
        done = 1'b0;

        // Timeout: 4 cycles per grant.
        req = 16'h0088;
        for (int c = 0; c < 9; c++) begin
            step("timeout");
            check($sformatf("timeout_sel%0d", c), 32'(sel), (c >= 4 && c < 8) ? 32'd7 : 32'd3);
        end
        req = '0;
        step("timeout_idle");

        // Withdrawal and stray done.
        req = 16'h0004;
        step("wd_grant"); check("wd_sel", 32'(sel), 32'd2);
        req = '0;
        step("wd_rel"); check("wd_rel_valid", 32'(valid), 32'd0);
        done = 1'b1;
        step("stray_done");
        req = 16'h0040;
        step("stray_grant");
        check("stray_grant_valid", 32'(valid), 32'd1);
        check("stray_grant_sel", 32'(sel), 32'd6);
        done = 1'b0; req = '0;
        step("stray_idle");

        // Done of grantee 4 while req[9] rises.
        req = 16'h0010;
        step("sim4"); check("sim4_sel", 32'(sel), 32'd4);
        req = 16'h0210; done = 1'b1;
        step("sim9");
        check("sim9_grant", 32'(grant), 32'h0200);
        check("sim9_sel", 32'(sel), 32'd9);
        step("sim4b"); check("sim4b_sel", 32'(sel), 32'd4);
        done = 1'b0; req = '0;
        step("sim_idle");

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                req = 16'($urandom);
            else if ($urandom_range(0, 3) == 0)
                req = 16'($urandom & $urandom & $urandom);
            done    = ($urandom_range(0, 4) == 0);
            data_in = 16'($urandom);
            step("rand");
            data_in = 16'($urandom);
            #1;
            check("rand_comb_dout", 32'(data_out),
                  (m_owner >= 0) ? 32'(data_in[m_owner]) : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
